// File: rtl/apb_uart_pkg.sv
// Shared register map and bit positions for the APB UART FIFO bridge.
package apb_uart_pkg;

    localparam logic [31:0] ADDR_DATA   = 32'h00;
    localparam logic [31:0] ADDR_CTRL   = 32'h04;
    localparam logic [31:0] ADDR_STATUS = 32'h08;

    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_RX_IE    = 2;
    localparam int CTRL_TX_IE    = 3;
    localparam int CTRL_OVF_IE   = 4;
    localparam int CTRL_TXFLUSH  = 5;
    localparam int CTRL_RXFLUSH  = 6;
    localparam int CTRL_STORED_W = 5;

    localparam int STATUS_TX_EMPTY  = 0;
    localparam int STATUS_TX_FULL   = 1;
    localparam int STATUS_RX_EMPTY  = 2;
    localparam int STATUS_RX_FULL   = 3;
    localparam int STATUS_RX_OVF    = 4;
    localparam int STATUS_TXCNT_LSB = 8;
    localparam int STATUS_RXCNT_LSB = 16;

    typedef enum logic [1:0] {
        REG_DATA,
        REG_CTRL,
        REG_STATUS,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_offset(input logic [31:0] offset);
        case (offset)
            ADDR_DATA:   return REG_DATA;
            ADDR_CTRL:   return REG_CTRL;
            ADDR_STATUS: return REG_STATUS;
            default:     return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a pop frees its slot for a same-cycle push, flush wins over both.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    // Head is forced to zero when empty so stale storage never leaks out.
    assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/apb_uart_fifo_bridge.sv
// APB slave exposing TX/RX FIFOs, control, status and a sticky overflow interrupt to a UART core.
module apb_uart_fifo_bridge
    import apb_uart_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int ADDR_W   = 6
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [1:0]        mode,
    output logic              irq
);

    localparam int TX_CNT_W = $clog2(TX_DEPTH + 1);
    localparam int RX_CNT_W = $clog2(RX_DEPTH + 1);

    logic [CTRL_STORED_W-1:0] r_ctrl;
    logic                     r_rx_ovf;
    logic                     r_irq;

    reg_sel_e            w_sel;
    logic                w_access, w_wr, w_rd;
    logic                w_tx_push, w_tx_pop, w_tx_flush, w_tx_full, w_tx_empty;
    logic                w_rx_pop, w_rx_flush, w_rx_full, w_rx_empty;
    logic                w_rd_data, w_ovf_set, w_ovf_clr;
    logic [TX_CNT_W-1:0] w_tx_count;
    logic [RX_CNT_W-1:0] w_rx_count;
    logic [DATA_W-1:0]   w_rx_dout;
    logic [31:0]         w_status;
    logic                w_unused_pwdata;

    assign w_sel      = decode_offset(32'(paddr));
    assign w_access   = psel & penable;
    assign w_wr       = w_access & pwrite;
    assign w_rd       = w_access & ~pwrite;
    assign w_rd_data  = w_rd & (w_sel == REG_DATA);

    assign w_tx_push  = w_wr & (w_sel == REG_DATA);
    assign w_tx_pop   = ~w_tx_empty & tx_ready;
    assign w_tx_flush = w_wr & (w_sel == REG_CTRL) & pwdata[CTRL_TXFLUSH];
    assign w_rx_pop   = w_rd_data & ~w_rx_empty;
    assign w_rx_flush = w_wr & (w_sel == REG_CTRL) & pwdata[CTRL_RXFLUSH];

    // A same-cycle APB pop makes room, so only an unrelieved full FIFO overflows.
    assign w_ovf_set  = rx_valid & w_rx_full & ~w_rx_pop & ~w_rx_flush;
    assign w_ovf_clr  = w_wr & (w_sel == REG_STATUS) & pwdata[STATUS_RX_OVF];
    assign w_unused_pwdata = ^pwdata;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_clk   (pclk),
        .i_rst_n (presetn),
        .i_push  (w_tx_push),
        .i_din   (pwdata[DATA_W-1:0]),
        .i_pop   (w_tx_pop),
        .i_flush (w_tx_flush),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count),
        .o_dout  (tx_data)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk   (pclk),
        .i_rst_n (presetn),
        .i_push  (rx_valid),
        .i_din   (rx_data),
        .i_pop   (w_rx_pop),
        .i_flush (w_rx_flush),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count),
        .o_dout  (w_rx_dout)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_ctrl   <= '0;
            r_rx_ovf <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && (w_sel == REG_CTRL)) r_ctrl <= pwdata[CTRL_STORED_W-1:0];
            if (w_ovf_set)      r_rx_ovf <= 1'b1;
            else if (w_ovf_clr) r_rx_ovf <= 1'b0;
            r_irq <= (r_ctrl[CTRL_RX_IE]  & ~w_rx_empty) |
                     (r_ctrl[CTRL_TX_IE]  &  w_tx_empty) |
                     (r_ctrl[CTRL_OVF_IE] &  r_rx_ovf);
        end
    end

    always_comb begin
        w_status = '0;
        w_status[STATUS_TX_EMPTY] = w_tx_empty;
        w_status[STATUS_TX_FULL]  = w_tx_full;
        w_status[STATUS_RX_EMPTY] = w_rx_empty;
        w_status[STATUS_RX_FULL]  = w_rx_full;
        w_status[STATUS_RX_OVF]   = r_rx_ovf;
        w_status[STATUS_TXCNT_LSB +: 8] = 8'(w_tx_count);
        w_status[STATUS_RXCNT_LSB +: 8] = 8'(w_rx_count);
    end

    always_comb begin
        prdata = '0;
        if (psel && !pwrite) begin
            case (w_sel)
                REG_DATA:   prdata = 32'(w_rx_dout);
                REG_CTRL:   prdata = 32'(r_ctrl);
                REG_STATUS: prdata = w_status;
                default:    prdata = '0;
            endcase
        end
    end

    assign pslverr  = w_access & ((w_sel == REG_NONE) |
                                  (w_tx_push & w_tx_full & ~w_tx_pop) |
                                  (w_rd_data & w_rx_empty));
    assign pready   = 1'b1;
    assign tx_valid = ~w_tx_empty;
    assign mode     = r_ctrl[CTRL_MODE_LSB +: 2];
    assign irq      = r_irq;

endmodule

// File: tb/tb_apb_uart_fifo_bridge.sv
// Scoreboard bench: stimulus queues expected APB responses and TX hand-offs, a monitor checks them.
module tb_apb_uart_fifo_bridge;

    localparam logic [5:0] A_DATA = 6'h00, A_CTRL = 6'h04, A_STATUS = 6'h08, A_RSVD = 6'h0C;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic [5:0]  paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [1:0]  mode;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        err;
    } apb_exp_t;

    apb_exp_t   apb_q[$];
    logic [7:0] tx_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    apb_uart_fifo_bridge dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .mode(mode), .irq(irq)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completed APB access and every TX hand-off consumes one expectation.
    always @(negedge pclk) begin
        if (psel && penable) begin
            if (apb_q.size() == 0) begin
                chk("apb_unexpected_access", 32'd1, 32'd0);
            end else begin
                apb_exp_t e;
                e = apb_q.pop_front();
                $display("apb %s: prdata=0x%08h pslverr=%0b", e.name, prdata, pslverr);
                chk({e.name, "_prdata"}, prdata, e.rd);
                chk({e.name, "_pslverr"}, 32'(pslverr), 32'(e.err));
            end
        end
        if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                chk("tx_unexpected_handoff", 32'd1, 32'd0);
            end else begin
                logic [7:0] t;
                t = tx_q.pop_front();
                $display("tx handoff: data=0x%02h", tx_data);
                chk("tx_data_handoff", 32'(tx_data), 32'(t));
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic apb(input string name, input logic wr, input logic [5:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
        apb_exp_t e;
        e.name = name;
        e.rd   = exp_rd;
        e.err  = exp_err;
        apb_q.push_back(e);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_data = d; rx_valid = 1'b1;
        @(posedge pclk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge pclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_tx_valid", 32'(tx_valid), 32'd0);
        chk("reset_tx_data", 32'(tx_data), 32'd0);
        chk("reset_pslverr", 32'(pslverr), 32'd0);
        presetn = 1'b1;
        tick();
        apb("rd_status_reset", 1'b0, A_STATUS, 0, 32'h0000_0005, 1'b0);

        // Two TX writes held back, then released
        apb("wr_data_a5", 1'b1, A_DATA, 32'hA5, 0, 1'b0);
        apb("wr_data_3c", 1'b1, A_DATA, 32'h3C, 0, 1'b0);
        chk("tx_valid_after_push", 32'(tx_valid), 32'd1);
        chk("tx_head_a5", 32'(tx_data), 32'hA5);
        apb("rd_status_tx2", 1'b0, A_STATUS, 0, 32'h0000_0204, 1'b0);
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h3C);
        tx_ready = 1'b1;
        tick(); tick();
        tx_ready = 1'b0;
        chk("tx_valid_drained", 32'(tx_valid), 32'd0);

        // Fill TX, overflow write rejected
        for (int i = 0; i < 16; i++) apb("wr_fill_tx", 1'b1, A_DATA, 32'h10 + i, 0, 1'b0);
        apb("wr_tx_full", 1'b1, A_DATA, 32'hEE, 0, 1'b1);
        apb("rd_status_tx_full", 1'b0, A_STATUS, 0, 32'h0000_1006, 1'b0);
        chk("tx_head_unchanged", 32'(tx_data), 32'h10);
        for (int i = 0; i < 16; i++) tx_q.push_back(8'(8'h10 + i));
        tx_ready = 1'b1;
        n = 0;
        while (tx_valid && n < 40) begin tick(); n++; end
        tx_ready = 1'b0;
        chk("tx_drain_in_time", 32'(n), 32'd16);

        // RX overflow, sticky flag and its interrupt
        apb("wr_ctrl_ovf_ie", 1'b1, A_CTRL, 32'h10, 0, 1'b0);
        for (int i = 1; i <= 17; i++) rx_pulse(8'(i));
        chk("irq_latency_ovf", 32'(irq), 32'd0);
        tick();
        chk("irq_ovf", 32'(irq), 32'd1);
        apb("rd_status_rx_ovf", 1'b0, A_STATUS, 0, 32'h0010_0019, 1'b0);
        for (int i = 1; i <= 16; i++) apb("rd_rx_data", 1'b0, A_DATA, 0, 32'(i), 1'b0);
        apb("rd_rx_empty", 1'b0, A_DATA, 0, 32'h0, 1'b1);
        apb("w1c_rx_ovf", 1'b1, A_STATUS, 32'h10, 0, 1'b0);
        tick();
        chk("irq_after_w1c", 32'(irq), 32'd0);
        apb("rd_status_cleared", 1'b0, A_STATUS, 0, 32'h0000_0005, 1'b0);

        // RX full with a same-cycle push and pop
        for (int i = 0; i < 16; i++) rx_pulse(8'(8'h21 + i));
        apb("rd_status_rx_full", 1'b0, A_STATUS, 0, 32'h0010_0009, 1'b0);
        begin
            apb_exp_t e;
            e.name = "rd_push_pop_full"; e.rd = 32'h21; e.err = 1'b0;
            apb_q.push_back(e);
            psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_DATA;
            tick();
            penable = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
            tick();
            psel = 1'b0; penable = 1'b0; rx_valid = 1'b0;
        end
        apb("rd_status_keep16", 1'b0, A_STATUS, 0, 32'h0010_0009, 1'b0);
        for (int i = 0; i < 15; i++) apb("rd_rx_drain", 1'b0, A_DATA, 0, 32'h22 + i, 1'b0);
        apb("rd_rx_last_77", 1'b0, A_DATA, 0, 32'h77, 1'b0);

        // RX-not-empty interrupt, two cycles from the strobe
        apb("wr_ctrl_rx_ie", 1'b1, A_CTRL, 32'h07, 0, 1'b0);
        chk("mode_bits", 32'(mode), 32'd3);
        tick();
        chk("irq_rx_empty", 32'(irq), 32'd0);
        rx_pulse(8'h5A);
        chk("irq_rx_lat1", 32'(irq), 32'd0);
        tick();
        chk("irq_rx_lat2", 32'(irq), 32'd1);
        apb("rd_rx_5a", 1'b0, A_DATA, 0, 32'h5A, 1'b0);
        chk("irq_still_set", 32'(irq), 32'd1);
        tick();
        chk("irq_after_pop", 32'(irq), 32'd0);

        // Flushes are self-clearing and empty the FIFOs
        apb("wr_tx_f1", 1'b1, A_DATA, 32'h11, 0, 1'b0);
        apb("wr_tx_f2", 1'b1, A_DATA, 32'h22, 0, 1'b0);
        apb("wr_ctrl_txflush", 1'b1, A_CTRL, 32'h27, 0, 1'b0);
        chk("tx_valid_flushed", 32'(tx_valid), 32'd0);
        apb("rd_ctrl_flush0", 1'b0, A_CTRL, 0, 32'h07, 1'b0);
        rx_pulse(8'h61);
        rx_pulse(8'h62);
        apb("wr_ctrl_rxflush", 1'b1, A_CTRL, 32'h47, 0, 1'b0);
        apb("rd_status_flushed", 1'b0, A_STATUS, 0, 32'h0000_0005, 1'b0);

        // Unmapped offset
        apb("rd_rsvd", 1'b0, A_RSVD, 0, 32'h0, 1'b1);
        apb("wr_rsvd", 1'b1, A_RSVD, 32'hFFFF_FFFF, 0, 1'b1);
        apb("rd_ctrl_intact", 1'b0, A_CTRL, 0, 32'h07, 1'b0);

        // TX-empty interrupt
        apb("wr_ctrl_tx_ie", 1'b1, A_CTRL, 32'h08, 0, 1'b0);
        tick();
        chk("irq_tx_empty", 32'(irq), 32'd1);

        // Asynchronous reset mid-stream drops everything
        apb("wr_before_rst", 1'b1, A_DATA, 32'h99, 0, 1'b0);
        rx_pulse(8'h44);
        presetn = 1'b0;
        #2;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_mode", 32'(mode), 32'd0);
        tick();
        presetn = 1'b1;
        tick();
        apb("rd_status_post_rst", 1'b0, A_STATUS, 0, 32'h0000_0005, 1'b0);
        apb("rd_data_post_rst", 1'b0, A_DATA, 0, 32'h0, 1'b1);

        tick();
        chk("apb_queue_drained", 32'(apb_q.size()), 32'd0);
        chk("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_uart_fifo_bridge.md
Name: apb_uart_fifo_bridge

Overview:
- APB slave bridging the CPU to a byte-stream UART core through parametrised TX and RX FIFOs.
- Successor to the fixed single-FIFO bridge. Adds:
  - generic data width and FIFO depths
  - valid/ready TX handshake
  - a status register
  - maskable, sticky interrupt sources
  - PSLVERR on illegal accesses
- Sits between the APB interconnect and the UART TX/RX engines; one clock domain.

Parameters:
- DATA_W, 8, UART character width (5..9); occupies the LSBs of the 32-bit APB data.
- TX_DEPTH, 16, TX FIFO entries; power of two, >=2.
- RX_DEPTH, 16, RX FIFO entries; power of two, >=2.
- ADDR_W, 6, APB address width; registers are word-aligned.

Ports:
- pclk  in  1  APB clock; the only clock.
- presetn  in  1  Asynchronous, active-low reset.
- paddr  in  ADDR_W  APB address.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write.
- pwdata  in  32  Write data.
- prdata  out  32  Read data, valid in the access phase.
- pready  out  1  Tied to 1 (zero wait states).
- pslverr  out  1  Error response, valid in the access phase.
- tx_data  out  DATA_W  Head of the TX FIFO.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  UART accepts tx_data when tx_valid & tx_ready.
- rx_data  in  DATA_W  Received character.
- rx_valid  in  1  One-cycle strobe: rx_data is valid.
- mode  out  2  UART mode bits = CTRL[1:0].
- irq  out  1  Registered interrupt.

Behaviour:
- Register map (byte offsets):
  - 0x00 DATA. Write pushes pwdata[DATA_W-1:0] to TX. Read returns the RX head zero-extended, and pops it.
  - 0x04 CTRL, R/W:
    - [1:0] mode
    - [2] rx_ie (RX not empty)
    - [3] tx_ie (TX empty)
    - [4] ovf_ie
    - [5] txflush, self-clearing: empties TX in one cycle and reads 0
    - [6] rxflush, self-clearing: empties RX in one cycle and reads 0
  - 0x08 STATUS, RO except W1C bit:
    - [0] tx_empty
    - [1] tx_full
    - [2] rx_empty
    - [3] rx_full
    - [4] rx_ovf, sticky, W1C
    - [15:8] tx_count
    - [23:16] rx_count
  - 0x0C RSVD. Reads 0 and asserts PSLVERR.
- An access completes on psel & penable. Side effects (push, pop, register update) happen only at that edge; the setup phase has none.
- PSLVERR is asserted with the access phase for:
  - write DATA while TX is full: data dropped
  - read DATA while RX is empty: prdata = 0, no pop
  - any access to an unmapped offset: writes ignored
- prdata is combinational from the FIFO head or the registers while psel & ~pwrite; otherwise 0.
- TX FIFO:
  - Show-ahead: tx_data is the head whenever tx_valid.
  - Pop on tx_valid & tx_ready.
  - A push and a pop in the same cycle leave the count unchanged, including when full, because the pop frees the slot first.
  - A push to an empty FIFO makes tx_valid = 1 the next cycle.
- RX FIFO:
  - Push on rx_valid.
  - rx_valid while full: the character is dropped and rx_ovf is set. Exception: an APB pop in the same cycle; then the push succeeds and rx_ovf is not set.
  - A simultaneous push and pop keeps the count.
- Flush has priority over a same-cycle push or pop on that FIFO.
- W1C of rx_ovf and a same-cycle overflow: the set wins.
- irq, updated every cycle:
  - irq <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty) | (ovf_ie & rx_ovf)
  - It uses post-update state, so there is one cycle of latency from the cause.
- Counts are DEPTH+1 values wide internally and saturate at DEPTH. Pointers wrap modulo DEPTH.
- Reset values:
  - All FIFOs empty, CTRL = 0, rx_ovf = 0.
  - irq = 0, tx_valid = 0, tx_data = 0, mode = 0.
  - pslverr = 0, prdata = 0.
  - Reset asserted mid-transfer discards all FIFO contents immediately.

Decomposition:
- Package apb_uart_pkg holds:
  - register offsets ADDR_DATA, ADDR_CTRL, ADDR_STATUS
  - CTRL and STATUS bit-position constants
- Sub-module sync_fifo (params WIDTH, DEPTH):
  - show-ahead
  - ports: push, pop, flush, full, empty, count, dout
  - instantiated twice, once for TX and once for RX

Test Plan:
- Reset, then read STATUS -> 0x00000005 (tx_empty, rx_empty); irq = 0; pslverr = 0.
- Write DATA 0xA5, then 0x3C, with tx_ready = 0 -> tx_valid = 1, tx_data = 0xA5, tx_count = 2. Raise tx_ready for 2 cycles -> 0xA5 then 0x3C handed off; tx_valid = 0.
- Fill TX with 16 writes, then a 17th write -> pslverr = 1 on the 17th, tx_count stays 16, and the head is unchanged.
- Pulse rx_valid 17 times with 0x01..0x11 and no pops -> rx_full = 1, rx_ovf = 1. With ovf_ie = 1, irq = 1 one cycle later. 16 DATA reads return 0x01..0x10. The 17th read returns 0 with pslverr = 1.
- With RX full, an rx_valid and a DATA read in the same cycle -> the read returns the head, rx_count stays 16, rx_ovf stays 0.
- Set rx_ie = 1 with RX empty -> irq = 0. One rx_valid of 0x5A -> irq = 1 after 2 cycles. Read DATA -> 0x5A; irq = 0 on the following cycle.
